// File: rtl/muxn_rr_reg_pkg.sv
// Shared definitions for the registered N-channel multiplexer.
//   mode_e     : MODE_SEL (direct select by s) / MODE_RR (round-robin)
//   DEF_WIDTH  : default data width per channel
//   DEF_NCH    : default number of input channels
package muxn_rr_reg_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_NCH   = 4;

endpackage

// File: rtl/muxn_rr_reg_rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at the channel after ptr and wraps modulo NCH, so the
// channel granted last has the lowest priority next time.
//   req     in   NCH   request per channel
//   ptr     in   SELW  last granted channel
//   en      in   1     evaluate a grant; no grant when low
//   gnt_idx out  SELW  granted channel index (0 when no grant)
//   gnt_any out  1     a channel was granted
module rr_arbiter #(
  parameter int unsigned NCH  = 4,
  localparam int unsigned SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            en,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  int unsigned idx;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (en) begin
      for (int unsigned k = 1; k <= NCH; k++) begin
        idx = (int'(ptr) + k) % NCH;
        if (!gnt_any && req[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = SELW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/muxn_rr_reg.sv
// Registered N-channel, W-bit multiplexer with valid/ready handshakes.
// Mode 0 forwards channel s; mode 1 arbitrates round-robin over valid
// channels. One output register stage; a new word loads in the same cycle
// the held word drains.
//   clk, rst_n   clock, synchronous active-low reset
//   in_data      NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid     NCH        channel i holds a word
//   in_ready     NCH        channel i word accepted this cycle (combinational)
//   s            SELW       channel select (mode 0)
//   mode         1          0 = MODE_SEL, 1 = MODE_RR
//   y, y_valid   registered output word and its valid
//   y_ready      downstream accepts y
//   y_ch         SELW       source channel of y
//   y_par        1          ^y, registered (only with MUXN_PARITY_EN)
// Optional feature macro: MUXN_PARITY_EN
module muxn_rr_reg
  import muxn_rr_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NCH   = DEF_NCH,
  localparam int unsigned SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      s,
  input  logic                 mode,
  output logic [WIDTH-1:0]     y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [SELW-1:0]      y_ch
`ifdef MUXN_PARITY_EN
  ,
  output logic                 y_par
`endif
);

  logic [SELW-1:0]  rr_ptr;
  logic             load_en;
  logic             rr_en;
  logic [SELW-1:0]  rr_idx;
  logic             rr_any;
  logic             sel_ok;
  logic             granted;
  logic [SELW-1:0]  grant;
  logic [WIDTH-1:0] sel_data;
  mode_e            mode_q;

  assign mode_q  = mode_e'(mode);
  // Gating with rst_n keeps in_ready low while reset is asserted.
  assign load_en = rst_n && (!y_valid || y_ready);
  assign rr_en   = load_en && (mode_q == MODE_RR);

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .en      (rr_en),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  always_comb begin
    sel_ok   = 1'b0;
    granted  = 1'b0;
    grant    = '0;
    in_ready = '0;
    if (int'(s) < NCH) begin
      sel_ok = in_valid[s];
    end
    if (mode_q == MODE_RR) begin
      granted = rr_any;
      grant   = rr_idx;
    end else begin
      granted = load_en && sel_ok;
      grant   = s;
    end
    if (load_en && granted) begin
      in_ready[grant] = 1'b1;
    end
  end

  assign sel_data = in_data[int'(grant)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
      y_ch    <= '0;
      rr_ptr  <= SELW'(NCH - 1);
    end else if (load_en) begin
      if (granted) begin
        y       <= sel_data;
        y_ch    <= grant;
        y_valid <= 1'b1;
        if (mode_q == MODE_RR) begin
          rr_ptr <= grant;
        end
      end else begin
        y_valid <= 1'b0;
      end
    end
  end

`ifdef MUXN_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_par <= 1'b0;
    end else if (load_en && granted) begin
      y_par <= ^sel_data;
    end
  end
`endif

endmodule

// File: tb/tb_muxn_rr_reg.sv
// Directed self-checking bench for muxn_rr_reg (WIDTH=8, NCH=4).
module tb_muxn_rr_reg;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  s;
  logic        mode;
  logic [7:0]  y;
  logic        y_valid;
  logic        y_ready;
  logic [1:0]  y_ch;
`ifdef MUXN_PARITY_EN
  logic        y_par;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  muxn_rr_reg #(.WIDTH(8), .NCH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s        (s),
    .mode     (mode),
    .y        (y),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y_ch     (y_ch)
`ifdef MUXN_PARITY_EN
    ,
    .y_par    (y_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  int unsigned ch;
  logic [3:0] one_hot;

  initial begin
    rst_n    = 1'b0;
    in_valid = 4'b1111;
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    mode     = 1'b0;
    s        = 2'd0;
    y_ready  = 1'b1;

    // reset with all channels valid
    tick();
    tick();
    check("rst_y", 32'(y), 32'h0);
    check("rst_y_valid", 32'(y_valid), 32'h0);
    check("rst_y_ch", 32'(y_ch), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h0);
`ifdef MUXN_PARITY_EN
    check("rst_y_par", 32'(y_par), 32'h0);
`endif

    // direct select of channel 2
    rst_n   = 1'b1;
    s       = 2'd2;
    in_data = {8'h13, 8'hA5, 8'h11, 8'h10};
    settle();
    check("sel_in_ready", 32'(in_ready), 32'b0100);
    tick();
    check("sel_y", 32'(y), 32'hA5);
    check("sel_y_ch", 32'(y_ch), 32'd2);
    check("sel_y_valid", 32'(y_valid), 32'h1);

    // round-robin, all valid; pointer still at 3 so channel 0 leads
    mode    = 1'b1;
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int unsigned i = 0; i < 5; i++) begin
      ch = i % 4;
      one_hot = 4'b0001 << ch;
      settle();
      check("rr_in_ready", 32'(in_ready), 32'(one_hot));
      tick();
      check("rr_y", 32'(y), 32'h10 + ch);
      check("rr_y_ch", 32'(y_ch), ch);
    end

    // backpressure holds channel 0's word
    y_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      settle();
      check("bp_in_ready", 32'(in_ready), 32'h0);
      tick();
      check("bp_y", 32'(y), 32'h10);
      check("bp_y_valid", 32'(y_valid), 32'h1);
      check("bp_y_ch", 32'(y_ch), 32'd0);
    end
    y_ready = 1'b1;
    settle();
    check("bp_rel_in_ready", 32'(in_ready), 32'b0010);
    tick();
    check("bp_rel_y", 32'(y), 32'h11);
    check("bp_rel_y_ch", 32'(y_ch), 32'd1);

    // sparse requests 1010 from pointer 1: 3, 1, 3
    in_valid = 4'b1010;
    for (int unsigned i = 0; i < 3; i++) begin
      ch = (i == 1) ? 1 : 3;
      one_hot = 4'b0001 << ch;
      settle();
      check("sp_in_ready", 32'(in_ready), 32'(one_hot));
      tick();
      check("sp_y_ch", 32'(y_ch), ch);
      check("sp_y", 32'(y), 32'h10 + ch);
    end

    // no requests: output empties, data and channel hold
    in_valid = 4'b0000;
    settle();
    check("idle_in_ready", 32'(in_ready), 32'h0);
    tick();
    check("idle_y_valid", 32'(y_valid), 32'h0);
    check("idle_y", 32'(y), 32'h13);
    check("idle_y_ch", 32'(y_ch), 32'd3);

    // mode 0 with the selected channel not valid
    mode     = 1'b0;
    s        = 2'd2;
    in_valid = 4'b0001;
    settle();
    check("selnv_in_ready", 32'(in_ready), 32'h0);
    tick();
    check("selnv_y_valid", 32'(y_valid), 32'h0);

    // mode 0 grant of channel 1 must not move the rr pointer (still 3)
    s        = 2'd1;
    in_valid = 4'b0010;
    settle();
    check("sel1_in_ready", 32'(in_ready), 32'b0010);
    tick();
    check("sel1_y", 32'(y), 32'h11);
    check("sel1_y_ch", 32'(y_ch), 32'd1);

    mode     = 1'b1;
    in_valid = 4'b1111;
    in_data  = {8'h13, 8'h12, 8'h11, 8'h07};
    settle();
    check("ptr_hold_in_ready", 32'(in_ready), 32'b0001);
    tick();
    check("ptr_hold_y", 32'(y), 32'h07);
    check("ptr_hold_y_ch", 32'(y_ch), 32'd0);
`ifdef MUXN_PARITY_EN
    check("par_y_par", 32'(y_par), 32'h1);
`endif

    // reset while a word is held
    y_ready = 1'b0;
    rst_n   = 1'b0;
    settle();
    check("mrst_in_ready", 32'(in_ready), 32'h0);
    tick();
    check("mrst_y_valid", 32'(y_valid), 32'h0);
    check("mrst_y", 32'(y), 32'h0);
    check("mrst_y_ch", 32'(y_ch), 32'h0);
`ifdef MUXN_PARITY_EN
    check("mrst_y_par", 32'(y_par), 32'h0);
`endif
    rst_n   = 1'b1;
    y_ready = 1'b1;
    settle();
    check("post_rst_in_ready", 32'(in_ready), 32'b0001);
    tick();
    check("post_rst_y_ch", 32'(y_ch), 32'd0);
    check("post_rst_y", 32'(y), 32'h07);
    check("post_rst_y_valid", 32'(y_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
